// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizes, sequencer states and lane packing helpers for the systolic sequencer.
package systolic_pkg;
  localparam int DIM = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DRAIN = 8;
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_CLEAR, ST_FEED, ST_DRAIN, ST_WRITE, ST_DONE
  } seqState;
  function automatic logic [DIM*AW-1:0] packLanes(input logic [AW-1:0] lanes [DIM]);
    logic [DIM*AW-1:0] bus;
    bus = '0;
    for (int i = 0; i < DIM; i++) bus[i*AW +: AW] = lanes[i];
    return bus;
  endfunction
  function automatic logic [AW-1:0] laneAddr(input logic [DIM*AW-1:0] bus, input int i);
    return bus[i*AW +: AW];
  endfunction
endpackage

// File: rtl/systolic_sequencer_if.sv
// systolic_sequencer_if: host handshake plus instruction, operand and output bank controls.
interface systolic_sequencer_if;
  import systolic_pkg::*;
  logic start, abort, busy, done;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_data;
  logic [DIM*AW-1:0] a_addr, b_addr;
  logic [DIM-1:0] a_valid, b_valid;
  logic pe_clr, pe_en, out_we;
  logic [AW-1:0] out_ptr;
  modport master (
    input start, abort, instr_data,
    output busy, done, instr_addr, a_addr, a_valid, b_addr, b_valid, pe_clr, pe_en, out_we, out_ptr
  );
  modport slave (
    output start, abort, instr_data,
    input busy, done, instr_addr, a_addr, a_valid, b_addr, b_valid, pe_clr, pe_en, out_we, out_ptr
  );
endinterface

// File: rtl/systolic_lane_addr.sv
// systolic_lane_addr: skewed A/B read addresses and valid for one array lane at tick t.
module systolic_lane_addr #(
  parameter int LANE = 0,
  parameter int DIM = 4,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic [AW:0]   t,
  input  logic [DW-1:0] k,
  input  logic [AW-1:0] aBase,
  input  logic [AW-1:0] bBase,
  input  logic          active,
  output logic [AW-1:0] aAddr,
  output logic [AW-1:0] bAddr,
  output logic          valid
);
  localparam logic [AW:0] L = (AW+1)'(LANE);
  logic [AW-1:0] step;
  assign step = AW'(t - L);
  assign valid = active && t >= L && t < (AW+1)'(k) + L;
  assign aAddr = valid ? aBase + AW'(LANE) * AW'(k) + step : '0;
  assign bAddr = valid ? bBase + step * AW'(DIM) + AW'(LANE) : '0;
endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: fetches tile descriptors and sequences feed, drain and result commit of the array.
module systolic_sequencer
  import systolic_pkg::*;
(
  input logic clk,
  input logic rst_n,
  systolic_sequencer_if.master bus
);
  seqState state, nextState;
  logic [AW:0] tick;
  logic [DW-1:0] k;
  logic [AW-1:0] aBase, bBase, instrAddr, outPtr, kDim;
  logic [AW-1:0] laneA [DIM];
  logic [AW-1:0] laneB [DIM];
  logic [DIM-1:0] laneV;
  logic lastFeed, lastDrain;
  assign kDim = AW'(k) * AW'(DIM);
  assign lastFeed = tick == (AW+1)'(k) + (AW+1)'(DIM-2);
  assign lastDrain = tick == (AW+1)'(DRAIN-1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      tick <= '0;
      k <= '0;
      aBase <= '0;
      bBase <= '0;
      instrAddr <= '0;
      outPtr <= '0;
    end else begin
      state <= nextState;
      tick <= !bus.abort && ((state == ST_FEED && !lastFeed) || (state == ST_DRAIN && !lastDrain)) ? tick + 1'b1 : '0;
      if (state == ST_DECODE) k <= bus.instr_data;
      if (bus.abort || (state == ST_IDLE && bus.start)) begin
        instrAddr <= '0;
        aBase <= '0;
        bBase <= '0;
        outPtr <= '0;
      end else if (state == ST_WRITE) begin
        instrAddr <= instrAddr + 1'b1;
        aBase <= aBase + kDim;
        bBase <= bBase + kDim;
        outPtr <= outPtr + AW'(DIM*DIM);
      end
    end
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   nextState = bus.start ? ST_FETCH : ST_IDLE;
      ST_FETCH:  nextState = ST_DECODE;
      ST_DECODE: nextState = bus.instr_data == '0 ? ST_DONE : ST_CLEAR;
      ST_CLEAR:  nextState = ST_FEED;
      ST_FEED:   nextState = lastFeed ? ST_DRAIN : ST_FEED;
      ST_DRAIN:  nextState = lastDrain ? ST_WRITE : ST_DRAIN;
      ST_WRITE:  nextState = ST_FETCH;
      default:   nextState = ST_IDLE;
    endcase
    if (bus.abort) nextState = ST_IDLE;
  end
  for (genvar g = 0; g < DIM; g++) begin : gLane
    systolic_lane_addr #(.LANE(g), .DIM(DIM), .AW(AW), .DW(DW)) uLane (
      .t(tick), .k(k), .aBase(aBase), .bBase(bBase), .active(state == ST_FEED),
      .aAddr(laneA[g]), .bAddr(laneB[g]), .valid(laneV[g])
    );
  end
  assign bus.a_addr = packLanes(laneA);
  assign bus.b_addr = packLanes(laneB);
  assign bus.a_valid = laneV;
  assign bus.b_valid = laneV;
  assign bus.busy = state != ST_IDLE && state != ST_DONE;
  assign bus.done = state == ST_DONE && !bus.abort;
  assign bus.pe_clr = state == ST_CLEAR;
  assign bus.pe_en = state == ST_FEED || state == ST_DRAIN;
  assign bus.out_we = state == ST_WRITE && !bus.abort;
  assign bus.instr_addr = instrAddr;
  assign bus.out_ptr = outPtr;
endmodule
